// File: rtl/demo_stream_arb.sv
// CH_NUM-channel stream aggregator: per-channel FIFOs drained by a round-robin or
// fixed-priority arbiter into one registered, channel-tagged output stream.

module demo_stream_arb_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [LVL_W-1:0]  level
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;

  assign head = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally; the explicit level distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module demo_stream_arb #(
  parameter int CH_NUM   = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0,
  parameter int ID_W     = $clog2(CH_NUM),
  parameter int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        in_valid,
  output logic [CH_NUM-1:0]        in_ready,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  input  logic [CH_NUM-1:0]        ch_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_ch,
  output logic [CH_NUM*LVL_W-1:0]  ch_level
);
  localparam logic [LVL_W-1:0] FULL  = LVL_W'(DEPTH);
  localparam logic [ID_W:0]    NCH   = (ID_W+1)'(CH_NUM);
  localparam logic [ID_W-1:0]  LAST  = ID_W'(CH_NUM - 1);

  logic [CH_NUM-1:0][DATA_W-1:0] ch_data, ch_head;
  logic [CH_NUM-1:0][LVL_W-1:0]  ch_lvl;
  logic [CH_NUM-1:0]             req, push, pop;
  logic [ID_W-1:0]               grant, rr_ptr;
  logic [ID_W:0]                 scan;
  logic                          found, load;

  assign ch_data  = in_data;
  assign ch_level = ch_lvl;
  assign load     = (|req) && (!out_valid || out_ready);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign in_ready[i] = !rst && (ch_lvl[i] != FULL);
    assign req[i]      = (ch_lvl[i] != '0) && ch_en[i];
    assign push[i]     = in_valid[i] && in_ready[i];
    assign pop[i]      = load && (grant == ID_W'(i));

    demo_stream_arb_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .LVL_W  (LVL_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (ch_data[i]),
      .head  (ch_head[i]),
      .level (ch_lvl[i])
    );
  end

  // Scan starts at rr_ptr (round-robin) or at 0 (fixed priority); first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      scan = (ARB_MODE == 1) ? (ID_W+1)'(k) : {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan >= NCH) scan = scan - NCH;
      if (!found && req[scan[ID_W-1:0]]) begin
        found = 1'b1;
        grant = scan[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ch_head[grant];
      out_ch    <= grant;
      if (ARB_MODE == 0) rr_ptr <= (grant == LAST) ? '0 : grant + ID_W'(1);
    end else if (out_ready) begin
      // Only reached with nothing to load, so the accepted beat leaves the bus.
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_demo_stream_arb.sv
// Bench for demo_stream_arb: a round-robin and a fixed-priority instance share stimulus;
// a queue-based reference model checks every cycle, plus a hand-computed vector table.

module tb_demo_stream_arb;
  localparam int N = 4, DW = 32, DEPTH = 4, LW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]   ch_en;
  logic           out_ready;

  logic [1:0]             ovld;
  logic [1:0][DW-1:0]     odata;
  logic [1:0][1:0]        och;
  logic [1:0][N-1:0]      irdy;
  logic [1:0][N*LW-1:0]   dlvl;

  int n_chk = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;

  demo_stream_arb #(.CH_NUM(N), .DATA_W(DW), .DEPTH(DEPTH), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
    .ch_en(ch_en), .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odata[0]),
    .out_ch(och[0]), .ch_level(dlvl[0]));

  demo_stream_arb #(.CH_NUM(N), .DATA_W(DW), .DEPTH(DEPTH), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
    .ch_en(ch_en), .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odata[1]),
    .out_ch(och[1]), .ch_level(dlvl[1]));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one queue per channel per instance, plus the output beat.
  logic [DW-1:0] mq [2][N][$];
  logic          m_vld [2];
  logic [DW-1:0] m_data [2];
  int            m_ch [2];
  int            m_rr [2];

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int sz [N];
      int win, best, d;
      if (rst) begin
        for (int i = 0; i < N; i++) mq[m][i].delete();
        m_vld[m] = 1'b0; m_data[m] = '0; m_ch[m] = 0; m_rr[m] = 0;
        continue;
      end
      for (int i = 0; i < N; i++) sz[i] = mq[m][i].size();
      win = -1; best = N;
      for (int i = 0; i < N; i++) begin
        if (sz[i] != 0 && ch_en[i]) begin
          d = (m == 1) ? i : (i - m_rr[m] + N) % N;
          if (d < best) begin best = d; win = i; end
        end
      end
      if (win >= 0 && (!m_vld[m] || out_ready)) begin
        m_data[m] = mq[m][win].pop_front();
        m_ch[m]   = win;
        m_vld[m]  = 1'b1;
        m_rr[m]   = (win + 1) % N;
      end else if (m_vld[m] && out_ready) begin
        m_vld[m] = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && sz[i] != DEPTH) mq[m][i].push_back(in_data[i*DW +: DW]);
    end
  endtask

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0]    e_rdy;
      logic [N*LW-1:0] e_lvl;
      for (int i = 0; i < N; i++) begin
        e_rdy[i] = !rst && (mq[m][i].size() != DEPTH);
        e_lvl[i*LW +: LW] = LW'(mq[m][i].size());
      end
      chk($sformatf("model out_valid dut%0d", m), 64'(ovld[m]), 64'(m_vld[m]));
      chk($sformatf("model out_data dut%0d", m), 64'(odata[m]), 64'(m_data[m]));
      chk($sformatf("model out_ch dut%0d", m), 64'(och[m]), 64'(m_ch[m]));
      chk($sformatf("model in_ready dut%0d", m), 64'(irdy[m]), 64'(e_rdy));
      chk($sformatf("model ch_level dut%0d", m), 64'(dlvl[m]), 64'(e_lvl));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    model_check();
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  ch;
    logic [31:0] d;
    logic        ordy;
    logic        e_ovld;
    logic [31:0] e_odata;
    logic [1:0]  e_och;
    logic [3:0]  e_irdy;
    logic [2:0]  e_lvl;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, int ch, logic [31:0] d, bit ordy,
                              bit eov, logic [31:0] eod, int ech, logic [3:0] eir, int elv);
    vec_t t;
    t.rst = r; t.vld = v; t.ch = 2'(ch); t.d = d; t.ordy = ordy;
    t.e_ovld = eov; t.e_odata = eod; t.e_och = 2'(ech); t.e_irdy = eir; t.e_lvl = 3'(elv);
    return t;
  endfunction

  localparam int NV = 23;
  vec_t tbl [NV];

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; ch_en = '1; out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin m_vld[m] = 0; m_data[m] = '0; m_ch[m] = 0; m_rr[m] = 0; end

    //            rst vld ch data         ordy ovld odata        och irdy     lvl(ch)
    tbl[0]  = mk(1, 0, 0, 32'h0,        1,   0,   32'h0,        0,  4'b0000, 0);
    tbl[1]  = mk(1, 0, 0, 32'h0,        1,   0,   32'h0,        0,  4'b0000, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        1,   0,   32'h0,        0,  4'b1111, 0);
    tbl[3]  = mk(0, 1, 2, 32'hA5A50001, 1,   0,   32'h0,        0,  4'b1111, 1);
    tbl[4]  = mk(0, 0, 2, 32'h0,        1,   1,   32'hA5A50001, 2,  4'b1111, 0);
    tbl[5]  = mk(0, 0, 2, 32'h0,        1,   0,   32'hA5A50001, 2,  4'b1111, 0);
    tbl[6]  = mk(0, 1, 1, 32'hB0,       0,   0,   32'hA5A50001, 2,  4'b1111, 1);
    tbl[7]  = mk(0, 1, 1, 32'hB1,       0,   1,   32'hB0,       1,  4'b1111, 1);
    tbl[8]  = mk(0, 1, 1, 32'hB2,       0,   1,   32'hB0,       1,  4'b1111, 2);
    tbl[9]  = mk(0, 1, 1, 32'hB3,       0,   1,   32'hB0,       1,  4'b1111, 3);
    tbl[10] = mk(0, 1, 1, 32'hB4,       0,   1,   32'hB0,       1,  4'b1101, 4);
    tbl[11] = mk(0, 1, 1, 32'hB5,       1,   1,   32'hB1,       1,  4'b1111, 3);
    tbl[12] = mk(0, 1, 1, 32'hB6,       0,   1,   32'hB1,       1,  4'b1101, 4);
    tbl[13] = mk(0, 0, 1, 32'h0,        1,   1,   32'hB2,       1,  4'b1111, 3);
    tbl[14] = mk(0, 0, 1, 32'h0,        1,   1,   32'hB3,       1,  4'b1111, 2);
    tbl[15] = mk(0, 0, 1, 32'h0,        1,   1,   32'hB4,       1,  4'b1111, 1);
    tbl[16] = mk(0, 0, 1, 32'h0,        1,   1,   32'hB6,       1,  4'b1111, 0);
    tbl[17] = mk(0, 0, 1, 32'h0,        1,   0,   32'hB6,       1,  4'b1111, 0);
    tbl[18] = mk(0, 1, 3, 32'hC0,       0,   0,   32'hB6,       1,  4'b1111, 1);
    tbl[19] = mk(0, 1, 3, 32'hC1,       0,   1,   32'hC0,       3,  4'b1111, 1);
    tbl[20] = mk(0, 1, 3, 32'hC2,       0,   1,   32'hC0,       3,  4'b1111, 2);
    tbl[21] = mk(1, 0, 3, 32'h0,        0,   0,   32'h0,        0,  4'b0000, 0);
    tbl[22] = mk(0, 0, 3, 32'h0,        0,   0,   32'h0,        0,  4'b1111, 0);

    for (int r = 0; r < NV; r++) begin
      rst = tbl[r].rst;
      in_valid = tbl[r].vld ? (4'b0001 << tbl[r].ch) : 4'b0000;
      in_data = '0;
      in_data[int'(tbl[r].ch)*DW +: DW] = tbl[r].d;
      ch_en = 4'hF;
      out_ready = tbl[r].ordy;
      step();
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("tbl%0d out_valid dut%0d", r, m), 64'(ovld[m]), 64'(tbl[r].e_ovld));
        chk($sformatf("tbl%0d out_data dut%0d", r, m), 64'(odata[m]), 64'(tbl[r].e_odata));
        chk($sformatf("tbl%0d out_ch dut%0d", r, m), 64'(och[m]), 64'(tbl[r].e_och));
        chk($sformatf("tbl%0d in_ready dut%0d", r, m), 64'(irdy[m]), 64'(tbl[r].e_irdy));
        chk($sformatf("tbl%0d ch_level dut%0d", r, m),
            64'(dlvl[m][int'(tbl[r].ch)*LW +: LW]), 64'(tbl[r].e_lvl));
      end
    end

    // Fairness: 2 beats preloaded on every channel while masked, then drained.
    ch_en = 4'h0; out_ready = 1'b0; in_valid = 4'hF;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'h100 + 32'(i*16 + k);
      step();
    end
    in_valid = '0; ch_en = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rr beat%0d valid", k), 64'(ovld[0]), 64'd1);
      chk($sformatf("rr beat%0d ch", k), 64'(och[0]), 64'(k % 4));
      chk($sformatf("fp beat%0d ch", k), 64'(och[1]), 64'(k / 2));
    end
    step();

    // Masking: ch0 held back while ch3 drains; unmasking then drains ch0.
    ch_en = 4'b1110; out_ready = 1'b1; in_valid = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      in_data = '0;
      in_data[0 +: DW] = 32'h200 + 32'(k);
      in_data[3*DW +: DW] = 32'h230 + 32'(k);
      step();
    end
    in_valid = '0;
    for (int k = 0; k < 3; k++) step();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("mask lvl0 dut%0d", m), 64'(dlvl[m][0 +: LW]), 64'd2);
      chk($sformatf("mask idle dut%0d", m), 64'(ovld[m]), 64'd0);
    end
    ch_en = 4'hF;
    for (int k = 0; k < 4; k++) step();
    for (int m = 0; m < 2; m++)
      chk($sformatf("unmask lvl0 dut%0d", m), 64'(dlvl[m][0 +: LW]), 64'd0);

    // Simultaneous push/pop on ch0 at level 2.
    ch_en = 4'h0; in_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin in_data = '0; in_data[0 +: DW] = 32'h300 + 32'(k); step(); end
    ch_en = 4'b0001;
    for (int k = 2; k < 8; k++) begin
      in_data = '0; in_data[0 +: DW] = 32'h300 + 32'(k);
      step();
      chk($sformatf("pushpop%0d lvl0", k), 64'(dlvl[0][0 +: LW]), 64'd2);
    end
    in_valid = '0;
    for (int k = 0; k < 4; k++) step();

    // Randomized traffic with occasional reset and masking.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      in_valid = 4'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      ch_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
